audio_frame_scheduler: RTL and testbench
========================================

Name: audio_frame_scheduler

Overview:
Single-clock sequencer for the ADC -> biquad -> DAC sample path. It replaces the divided-clock frame counter with a prescaled clock-enable and one-cycle strobes (adc_start, filt_strobe, dac_load) on the system clock. It also owns the biquad coefficient bank: a host writes a shadow copy through a valid/ready port, and a commit copies the whole bank to the active outputs atomically at the next frame boundary. The filter therefore never sees a mixed coefficient set.

Parameters:
CLK_DIV, 32, system clocks per slot tick (>=2)
FRAME_LEN, 22, slots per sample frame (>=3)
FILT_SLOT, 20, slot entered when filt_strobe fires (1..FRAME_LEN-1)
DAC_SLOT, 21, slot entered when dac_load fires (1..FRAME_LEN-1, != FILT_SLOT)
COEF_W, 17, coefficient magnitude width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  out  1  slot clock-enable, one clk wide every CLK_DIV clks
slot  out  5  current slot index, 0..FRAME_LEN-1
adc_start  out  1  one-clk strobe, frame start (slot entered 0)
filt_strobe  out  1  one-clk strobe, slot entered FILT_SLOT
dac_load  out  1  one-clk strobe, slot entered DAC_SLOT
cfg_valid  in  1  host write request
cfg_ready  out  1  shadow bank writable
cfg_addr  in  3  0=x0 1=x1 2=x2 3=y1 4=y2; 5..7 reserved
cfg_data  in  COEF_W  coefficient magnitude
cfg_neg  in  1  coefficient sign (1 = negative)
cfg_commit  in  1  request to apply the shadow bank at the next frame boundary
commit_pending  out  1  commit accepted, not yet applied
coef_update  out  1  one-clk pulse when the active bank changes
x0,x1,x2,y1,y2  out  COEF_W each  active coefficient magnitudes
x0_neg,x1_neg,x2_neg,y1_neg,y2_neg  out  1 each  active coefficient signs

Behaviour:
- Reset (async assert, sync release): prescaler=0, slot=0, tick, all strobes, coef_update and commit_pending = 0; shadow and active banks all 0; cfg_ready=1.
- Prescaler counts 0..CLK_DIV-1 and wraps. tick is high exactly while the count = CLK_DIV-1, first at the CLK_DIV-th edge after release.
- slot advances on each edge where tick=1 and wraps FRAME_LEN-1 -> 0.
- All strobes are registered. Each is high for the single clk following the edge at which slot takes its trigger value.
- adc_start: slot 0 entered by wrap. It does not fire at reset release.
- filt_strobe and dac_load are never high together and are never high with adc_start.
- Write handshake: a write is accepted on an edge with cfg_valid & cfg_ready. shadow[cfg_addr] <= {cfg_neg, cfg_data}. Reserved addresses are accepted and discarded.
- cfg_ready = ~commit_pending (combinational from the register). A writer stalled by a pending commit must hold its request stable.
- Commit: cfg_commit high with commit_pending=0 sets commit_pending on that edge. cfg_commit while already pending is ignored.
- Write and commit on the same edge: the write lands in shadow first, so the commit includes it.
- Apply: on the edge where slot wraps to 0 with commit_pending=1: active <= shadow, commit_pending <= 0, coef_update=1 for one clk, aligned with adc_start.
- A commit set on the wrap edge itself is applied at the following boundary.
- Active outputs change only at apply. Shadow contents are never visible on the outputs before apply.
- Reset mid-frame or mid-commit: everything returns to reset values, the pending commit is lost and the active bank clears to 0.

Test Plan:
- Reset then free-run with defaults -> tick at edges 32,64,...; filt_strobe after edge 640, dac_load after 672, adc_start after 704, then every 704 clks; each strobe exactly 1 clk wide.
- Write x0=0x00100/neg=0, y1=0x08000/neg=1, then commit at edge 100 -> outputs stay 0 until edge 704; then x0=0x00100, y1=0x08000, y1_neg=1, coef_update=1 together with adc_start.
- Hold cfg_valid with addr=2 while commit_pending=1 -> cfg_ready=0, x2 in the shadow is unchanged; the write is accepted on the first edge after apply; x2 reaches the outputs only after a second commit and boundary.
- Write addr=4 and cfg_commit on the same edge -> y2 takes the new value at the next boundary.
- Write addr=6 data=0x1FFFF, then commit -> all active outputs unchanged; coef_update still pulses.
- Assert rst_n=0 at slot 10 with a commit pending -> all outputs 0 immediately; after release the first adc_start is 704 clks later and there is no coef_update.

Source files
------------

// File: rtl/audio_frame_scheduler.sv
// ---------------------------------------------------------------------------
// audio_frame_scheduler
//
// Single-clock sequencer for the ADC -> biquad -> DAC sample path. A
// prescaler produces a slot clock-enable (tick) and the slot counter walks
// through one sample frame. Registered one-clk strobes mark frame start
// (adc_start), filter start (filt_strobe) and DAC load (dac_load).
//
// It also holds the biquad coefficient bank. The host writes a shadow copy
// through a valid/ready port. A commit copies the whole shadow bank into
// the active bank at the next frame boundary, so the filter never sees a
// mixed coefficient set.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   tick                slot clock-enable, one clk every CLK_DIV clks
//   slot                current slot index 0..FRAME_LEN-1
//   adc_start           strobe: slot 0 entered by wrap
//   filt_strobe         strobe: slot FILT_SLOT entered
//   dac_load            strobe: slot DAC_SLOT entered
//   cfg_valid/ready     shadow write handshake
//   cfg_addr            0=x0 1=x1 2=x2 3=y1 4=y2, 5..7 accepted and dropped
//   cfg_data, cfg_neg   coefficient magnitude and sign
//   cfg_commit          request to apply shadow at the next frame boundary
//   commit_pending      commit accepted but not yet applied
//   coef_update         one-clk pulse when the active bank changes
//   x0..y2, *_neg       active coefficient magnitudes and signs
// ---------------------------------------------------------------------------
module audio_frame_scheduler #(
  parameter int CLK_DIV   = 32,
  parameter int FRAME_LEN = 22,
  parameter int FILT_SLOT = 20,
  parameter int DAC_SLOT  = 21,
  parameter int COEF_W    = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              tick,
  output logic [4:0]        slot,
  output logic              adc_start,
  output logic              filt_strobe,
  output logic              dac_load,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              cfg_neg,
  input  logic              cfg_commit,
  output logic              commit_pending,
  output logic              coef_update,
  output logic [COEF_W-1:0] x0,
  output logic [COEF_W-1:0] x1,
  output logic [COEF_W-1:0] x2,
  output logic [COEF_W-1:0] y1,
  output logic [COEF_W-1:0] y2,
  output logic              x0_neg,
  output logic              x1_neg,
  output logic              x2_neg,
  output logic              y1_neg,
  output logic              y2_neg
);

  localparam int PW    = $clog2(CLK_DIV);
  localparam int NCOEF = 5;
  localparam int EW    = COEF_W + 1;  // {sign, magnitude}

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [4:0]    SLOT_LAST  = 5'(FRAME_LEN - 1);
  // Strobes are registered, so they are decoded from the slot just before
  // the trigger slot while tick is high.
  localparam logic [4:0]    FILT_PREV  = 5'(FILT_SLOT - 1);
  localparam logic [4:0]    DAC_PREV   = 5'(DAC_SLOT - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    slot_q, slot_d;
  logic          adc_start_q, adc_start_d;
  logic          filt_strobe_q, filt_strobe_d;
  logic          dac_load_q, dac_load_d;
  logic          commit_pending_q, commit_pending_d;
  logic          coef_update_q, coef_update_d;

  logic tick_w;
  logic wrap_w;
  logic wr_en_w;
  logic apply_w;

  logic [EW-1:0] active_bus [NCOEF];

  // Frame timing and commit control.
  always_comb begin
    tick_w  = (presc_q == PRESC_LAST);
    wrap_w  = tick_w && (slot_q == SLOT_LAST);
    presc_d = tick_w ? '0 : presc_q + 1'b1;

    slot_d = slot_q;
    if (tick_w) begin
      slot_d = wrap_w ? 5'd0 : slot_q + 5'd1;
    end

    adc_start_d   = wrap_w;
    filt_strobe_d = tick_w && (slot_q == FILT_PREV);
    dac_load_d    = tick_w && (slot_q == DAC_PREV);

    // Writes are blocked while a commit is pending, so the shadow bank that
    // gets applied is exactly the one that existed when the commit landed.
    wr_en_w = cfg_valid && !commit_pending_q;
    apply_w = wrap_w && commit_pending_q;

    // apply needs pending=1 and a new commit needs pending=0, so a commit
    // arriving on the wrap edge itself waits for the following boundary.
    commit_pending_d = commit_pending_q;
    if (apply_w) begin
      commit_pending_d = 1'b0;
    end else if (cfg_commit && !commit_pending_q) begin
      commit_pending_d = 1'b1;
    end

    coef_update_d = apply_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q          <= '0;
      slot_q           <= '0;
      adc_start_q      <= 1'b0;
      filt_strobe_q    <= 1'b0;
      dac_load_q       <= 1'b0;
      commit_pending_q <= 1'b0;
      coef_update_q    <= 1'b0;
    end else begin
      presc_q          <= presc_d;
      slot_q           <= slot_d;
      adc_start_q      <= adc_start_d;
      filt_strobe_q    <= filt_strobe_d;
      dac_load_q       <= dac_load_d;
      commit_pending_q <= commit_pending_d;
      coef_update_q    <= coef_update_d;
    end
  end

  // One shadow/active register pair per coefficient. Reserved addresses
  // match no entry and so are accepted without effect.
  generate
    for (genvar gi = 0; gi < NCOEF; gi++) begin : g_coef
      logic [EW-1:0] shadow_q, shadow_d;
      logic [EW-1:0] active_q, active_d;

      always_comb begin
        shadow_d = shadow_q;
        if (wr_en_w && (cfg_addr == 3'(gi))) begin
          shadow_d = {cfg_neg, cfg_data};
        end
        active_d = apply_w ? shadow_q : active_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q <= '0;
          active_q <= '0;
        end else begin
          shadow_q <= shadow_d;
          active_q <= active_d;
        end
      end

      assign active_bus[gi] = active_q;
    end
  endgenerate

  assign tick           = tick_w;
  assign slot           = slot_q;
  assign adc_start      = adc_start_q;
  assign filt_strobe    = filt_strobe_q;
  assign dac_load       = dac_load_q;
  assign cfg_ready      = ~commit_pending_q;
  assign commit_pending = commit_pending_q;
  assign coef_update    = coef_update_q;

  assign x0     = active_bus[0][COEF_W-1:0];
  assign x1     = active_bus[1][COEF_W-1:0];
  assign x2     = active_bus[2][COEF_W-1:0];
  assign y1     = active_bus[3][COEF_W-1:0];
  assign y2     = active_bus[4][COEF_W-1:0];
  assign x0_neg = active_bus[0][COEF_W];
  assign x1_neg = active_bus[1][COEF_W];
  assign x2_neg = active_bus[2][COEF_W];
  assign y1_neg = active_bus[3][COEF_W];
  assign y2_neg = active_bus[4][COEF_W];

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_audio_frame_scheduler
//
// Directed bench for audio_frame_scheduler with default parameters. Timing
// is tracked by counting clock edges since reset release (edge_n); all
// expected values are hand-derived from the slot/frame arithmetic
// (32 clks per slot, 704 clks per frame).
// ---------------------------------------------------------------------------
module tb_audio_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick;
  logic [4:0]  slot;
  logic        adc_start, filt_strobe, dac_load;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_addr = 3'd0;
  logic [16:0] cfg_data = 17'd0;
  logic        cfg_neg = 1'b0;
  logic        cfg_commit = 1'b0;
  logic        commit_pending, coef_update;
  logic [16:0] x0, x1, x2, y1, y2;
  logic        x0_neg, x1_neg, x2_neg, y1_neg, y2_neg;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n;

  audio_frame_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .slot(slot),
    .adc_start(adc_start), .filt_strobe(filt_strobe), .dac_load(dac_load),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_neg(cfg_neg), .cfg_commit(cfg_commit),
    .commit_pending(commit_pending), .coef_update(coef_update),
    .x0(x0), .x1(x1), .x2(x2), .y1(y1), .y2(y2),
    .x0_neg(x0_neg), .x1_neg(x1_neg), .x2_neg(x2_neg),
    .y1_neg(y1_neg), .y2_neg(y2_neg)
  );

  always #5 clk = ~clk;

  // Edge count since the most recent reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  function automatic logic [89:0] bank();
    return {x0_neg, x0, x1_neg, x1, x2_neg, x2, y1_neg, y1, y2_neg, y2};
  endfunction

  // Advance until edge_n reaches t, sampling 1 time unit after each edge.
  task automatic wait_edge(input int t);
    int guard = 0;
    while (edge_n < t) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 20000) begin
        $display("FAIL wait_edge: edge_n=%0d required=%0d", edge_n, t);
        $fatal(1, "wait bound expired");
      end
    end
  endtask

  // Present one cycle of host stimulus; returns 1 unit after the edge.
  task automatic drive(input logic v, input logic [2:0] a, input logic [16:0] d,
                       input logic ng, input logic c);
    cfg_valid = v; cfg_addr = a; cfg_data = d; cfg_neg = ng; cfg_commit = c;
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    #12;
    obs = {tick, slot, adc_start, filt_strobe, dac_load, coef_update};
    n_assert++;
    if (obs !== 10'd0) begin
      n_fail++; $display("FAIL reset_strobes: got %h required 000", obs);
    end
    n_assert++;
    if ({commit_pending, cfg_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_cfg: got %b required 01", {commit_pending, cfg_ready});
    end
    n_assert++;
    if (bank() !== 90'd0) begin
      n_fail++; $display("FAIL reset_bank: got %h required 0", bank());
    end
    @(negedge clk); rst_n = 1'b1;
    $display("test_reset: reset values checked");
  endtask

  task automatic test_free_run();
    logic [8:0] obs, exp_v;
    int bad = 0;
    for (int n = 1; n <= 1408; n++) begin
      @(posedge clk); #1;
      exp_v = {(n % 32) == 31, 5'((n / 32) % 22), (n % 704) == 0,
               (n % 704) == 640, (n % 704) == 672};
      obs = {tick, slot, adc_start, filt_strobe, dac_load};
      n_assert++;
      if (obs !== exp_v) begin
        n_fail++; bad++;
        if (bad <= 8)
          $display("FAIL free_run edge %0d: {tick,slot,adc,filt,dac} got %h required %h",
                   n, obs, exp_v);
      end
    end
    $display("test_free_run: 1408 edges of tick/slot/strobe timing checked");
  endtask

  task automatic test_commit();
    drive(1'b1, 3'd0, 17'h00100, 1'b0, 1'b0);   // x0, edge 1
    drive(1'b1, 3'd3, 17'h08000, 1'b1, 1'b0);   // y1, edge 2
    wait_edge(99);
    drive(1'b0, 3'd0, 17'd0, 1'b0, 1'b1);       // commit, edge 100
    n_assert++;
    if ({commit_pending, cfg_ready} !== 2'b10) begin
      n_fail++; $display("FAIL commit_set: got %b required 10", {commit_pending, cfg_ready});
    end
    wait_edge(703);
    n_assert++;
    if ({bank(), coef_update} !== 91'd0) begin
      n_fail++; $display("FAIL commit_early: got %h required 0", {bank(), coef_update});
    end
    wait_edge(704);
    n_assert++;
    if ({x0, y1, y1_neg, x0_neg} !== {17'h00100, 17'h08000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL commit_apply: x0=%h y1=%h y1_neg=%b required 00100 08000 1",
                         x0, y1, y1_neg);
    end
    n_assert++;
    if ({coef_update, adc_start, commit_pending} !== 3'b110) begin
      n_fail++; $display("FAIL commit_pulse: got %b required 110",
                         {coef_update, adc_start, commit_pending});
    end
    wait_edge(705);
    n_assert++;
    if ({coef_update, x0} !== {1'b0, 17'h00100}) begin
      n_fail++; $display("FAIL commit_after: got %h required 00100", {coef_update, x0});
    end
    $display("test_commit: x0/y1 applied at frame boundary");
  endtask

  task automatic test_stall();
    int ready_bad = 0;
    wait_edge(709);
    drive(1'b0, 3'd0, 17'd0, 1'b0, 1'b1);       // commit at 710, shadow unchanged
    wait_edge(719);
    cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 17'h00ABC; cfg_neg = 1'b0;
    for (int n = 720; n <= 1407; n++) begin
      @(posedge clk); #1;
      if (cfg_ready !== 1'b0) ready_bad++;
    end
    n_assert++;
    if (ready_bad != 0) begin
      n_fail++; $display("FAIL stall_ready: ready high on %0d edges, required 0", ready_bad);
    end
    @(posedge clk); #1;                          // edge 1408, apply
    n_assert++;
    if ({x2, x0, coef_update, cfg_ready} !== {17'd0, 17'h00100, 2'b11}) begin
      n_fail++; $display("FAIL stall_apply: x2=%h x0=%h upd=%b rdy=%b required 0 00100 1 1",
                         x2, x0, coef_update, cfg_ready);
    end
    @(posedge clk); #1;                          // edge 1409, write accepted
    cfg_valid = 1'b0;
    n_assert++;
    if ({x2, commit_pending} !== 18'd0) begin
      n_fail++; $display("FAIL stall_accept: x2=%h pend=%b required 0 0", x2, commit_pending);
    end
    wait_edge(1419);
    drive(1'b0, 3'd0, 17'd0, 1'b0, 1'b1);       // commit at 1420
    wait_edge(2111);
    n_assert++;
    if (x2 !== 17'd0) begin
      n_fail++; $display("FAIL stall_early: x2=%h required 0", x2);
    end
    wait_edge(2112);
    n_assert++;
    if ({x2, x2_neg, coef_update} !== {17'h00ABC, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL stall_second: x2=%h neg=%b upd=%b required 00abc 0 1",
                         x2, x2_neg, coef_update);
    end
    $display("test_stall: stalled x2 write applied after second commit");
  endtask

  task automatic test_same_edge();
    wait_edge(2119);
    drive(1'b1, 3'd4, 17'h01234, 1'b1, 1'b1);   // write y2 and commit at 2120
    n_assert++;
    if (commit_pending !== 1'b1) begin
      n_fail++; $display("FAIL same_edge_pend: got %b required 1", commit_pending);
    end
    wait_edge(2816);
    n_assert++;
    if ({y2, y2_neg, coef_update, adc_start} !== {17'h01234, 3'b111}) begin
      n_fail++; $display("FAIL same_edge_apply: y2=%h neg=%b upd=%b adc=%b required 01234 1 1 1",
                         y2, y2_neg, coef_update, adc_start);
    end
    $display("test_same_edge: write+commit on one edge applied");
  endtask

  task automatic test_reserved();
    logic [89:0] exp_b;
    exp_b = {1'b0, 17'h00100, 1'b0, 17'd0, 1'b0, 17'h00ABC,
             1'b1, 17'h08000, 1'b1, 17'h01234};
    wait_edge(2819);
    drive(1'b1, 3'd6, 17'h1FFFF, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 17'd0, 1'b0, 1'b1);       // commit at 2821
    wait_edge(3520);
    n_assert++;
    if (bank() !== exp_b) begin
      n_fail++; $display("FAIL reserved_bank: got %h required %h", bank(), exp_b);
    end
    n_assert++;
    if (coef_update !== 1'b1) begin
      n_fail++; $display("FAIL reserved_update: got %b required 1", coef_update);
    end
    $display("test_reserved: reserved write left bank unchanged");
  endtask

  task automatic test_reset_mid_commit();
    int bad = 0;
    wait_edge(3529);
    drive(1'b0, 3'd0, 17'd0, 1'b0, 1'b1);       // commit at 3530
    wait_edge(3840);
    n_assert++;
    if ({slot, commit_pending} !== {5'd10, 1'b1}) begin
      n_fail++; $display("FAIL mid_slot: slot=%0d pend=%b required 10 1", slot, commit_pending);
    end
    wait_edge(3845);
    #1 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({bank(), commit_pending, coef_update, slot, tick} !== 98'd0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: bank=%h pend=%b slot=%0d rdy=%b required all 0, rdy 1",
                         bank(), commit_pending, slot, cfg_ready);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 703; n++) begin
      @(posedge clk); #1;
      if (adc_start !== 1'b0 || coef_update !== 1'b0) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mid_quiet: early adc/update on %0d edges, required 0", bad);
    end
    @(posedge clk); #1;                          // edge 704
    n_assert++;
    if ({adc_start, coef_update, commit_pending} !== 3'b100) begin
      n_fail++; $display("FAIL mid_first_frame: got %b required 100",
                         {adc_start, coef_update, commit_pending});
    end
    // Shadow must have cleared too: a fresh commit applies an all-zero bank.
    wait_edge(709);
    drive(1'b0, 3'd0, 17'd0, 1'b0, 1'b1);
    wait_edge(1408);
    n_assert++;
    if ({bank(), coef_update} !== {90'd0, 1'b1}) begin
      n_fail++; $display("FAIL mid_shadow: got %h required 1", {bank(), coef_update});
    end
    $display("test_reset_mid_commit: pending commit dropped on reset");
  endtask

  initial begin
    test_reset();
    test_free_run();
    do_reset();
    test_commit();
    test_stall();
    test_same_edge();
    test_reserved();
    test_reset_mid_commit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
